// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing from a single clock with a pixel clock-enable.
// Decoded outputs are registered from next-state counters so they align with hCount/vCount.
module vga_timing_gen #(
    parameter int   CLK_DIV  = 4,
    parameter int   CW       = 11,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_ce,
    output logic [CW-1:0] hCount,
    output logic [CW-1:0] vCount,
    output logic          hSync,
    output logic          vSync,
    output logic          bright,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HA0     = H_SYNC + H_BP;
    localparam int VA0     = V_SYNC + V_BP;
    localparam int CEW     = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    generate
        if (H_TOTAL > 2 ** CW || V_TOTAL > 2 ** CW) begin : g_bad_width
            $error("vga_timing_gen: raster totals do not fit in CW bits");
        end
    endgenerate

    logic [CEW-1:0] ce_cnt;
    logic [CW-1:0]  h_nxt, v_nxt;
    logic           h_wrap, h_act, v_act, ls_q, fs_q;

    always_comb begin
        pix_ce = en & ~rst & (ce_cnt == CEW'(CLK_DIV - 1));
        h_wrap = hCount == CW'(H_TOTAL - 1);
        h_nxt  = pix_ce ? (h_wrap ? '0 : hCount + 1'b1) : hCount;
        v_nxt  = (pix_ce & h_wrap) ? (vCount == CW'(V_TOTAL - 1) ? '0 : vCount + 1'b1) : vCount;
        h_act  = h_nxt >= CW'(HA0) && h_nxt <= CW'(HA0 + H_ACTIVE - 1);
        v_act  = v_nxt >= CW'(VA0) && v_nxt <= CW'(VA0 + V_ACTIVE - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_cnt <= '0;
            hCount <= CW'(H_TOTAL - 1);
            vCount <= CW'(V_TOTAL - 1);
            hSync  <= ~HS_POL;
            vSync  <= ~VS_POL;
            bright <= 1'b0;
            x      <= '0;
            y      <= '0;
            vblank <= 1'b1;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            // pulse registers clear while frozen so a stale pulse never reappears on resume
            ls_q <= pix_ce & (h_nxt == '0);
            fs_q <= pix_ce & (h_nxt == '0) & (v_nxt == '0);
            if (en) begin
                ce_cnt <= pix_ce ? '0 : ce_cnt + 1'b1;
                hCount <= h_nxt;
                vCount <= v_nxt;
                hSync  <= h_nxt < CW'(H_SYNC) ? HS_POL : ~HS_POL;
                vSync  <= v_nxt < CW'(V_SYNC) ? VS_POL : ~VS_POL;
                bright <= h_act & v_act;
                x      <= (h_act & v_act) ? h_nxt - CW'(HA0) : '0;
                y      <= (h_act & v_act) ? v_nxt - CW'(VA0) : '0;
                vblank <= ~v_act;
            end
        end
    end

    assign line_start  = ls_q & en;
    assign frame_start = fs_q & en;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a default-timing and a tiny-raster instance against a linear-position model.
// The model maps enabled clocks to a pixel index and decodes position, sync and window arithmetically.
module tb_vga_timing_gen;
    logic clk = 1'b0, rst, en;
    always #5 clk = ~clk;

    logic        pce_a, hs_a, vs_a, br_a, ls_a, fs_a, vb_a;
    logic [10:0] hc_a, vc_a, x_a, y_a;
    logic        pce_b, hs_b, vs_b, br_b, ls_b, fs_b, vb_b;
    logic [10:0] hc_b, vc_b, x_b, y_b;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pce_a), .hCount(hc_a), .vCount(vc_a),
        .hSync(hs_a), .vSync(vs_a), .bright(br_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a), .vblank(vb_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(1), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
        .V_SYNC(1), .V_BP(2), .V_ACTIVE(1), .V_FP(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pce_b), .hCount(hc_b), .vCount(vc_b),
        .hSync(hs_b), .vSync(vs_b), .bright(br_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b), .vblank(vb_b)
    );

    typedef struct {int h, v; bit hs, vs, br; int x, y; bit vb;} exp_t;
    typedef struct {bit rst, en; int n, h, v; bit hs, vs, br; int x, y; bit ls, fs, vb;} vec_t;

    int     checks = 0, errors = 0;
    longint ta, tb_n;
    bit     lsa, fsa, lsb, fsb, pcea, pceb;
    exp_t   ea, eb;
    vec_t   tbl[13];

    function automatic exp_t decode(int hsw, int hbp, int hact, int hfp, int vsw, int vbp,
                                    int vact, int vfp, bit hp, bit vp, longint n);
        exp_t   d;
        longint ht, vt, pos;
        bit     ha, va;
        ht   = hsw + hbp + hact + hfp;
        vt   = vsw + vbp + vact + vfp;
        // pixel index 0 is the reset position (last pixel of the frame)
        pos  = (ht * vt - 1 + n) % (ht * vt);
        d.h  = int'(pos % ht);
        d.v  = int'(pos / ht);
        d.hs = d.h < hsw ? hp : !hp;
        d.vs = d.v < vsw ? vp : !vp;
        ha   = d.h >= hsw + hbp && d.h < hsw + hbp + hact;
        va   = d.v >= vsw + vbp && d.v < vsw + vbp + vact;
        d.br = ha && va;
        d.x  = d.br ? d.h - (hsw + hbp) : 0;
        d.y  = d.br ? d.v - (vsw + vbp) : 0;
        d.vb = !va;
        return d;
    endfunction

    function automatic exp_t dec_a(longint n);
        return decode(96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0, n);
    endfunction

    function automatic exp_t dec_b(longint n);
        return decode(1, 1, 4, 1, 1, 2, 1, 1, 1'b1, 1'b1, n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic cmp(input string t, input exp_t e, input bit pe, input bit le, input bit fe,
                       input logic p, input logic [10:0] h, input logic [10:0] v, input logic hs,
                       input logic vs, input logic br, input logic [10:0] x, input logic [10:0] y,
                       input logic ls, input logic fs, input logic vb);
        chk({t, ".pix_ce"}, p, pe);
        chk({t, ".hCount"}, h, e.h);
        chk({t, ".vCount"}, v, e.v);
        chk({t, ".hSync"}, hs, e.hs);
        chk({t, ".vSync"}, vs, e.vs);
        chk({t, ".bright"}, br, e.br);
        chk({t, ".x"}, x, e.x);
        chk({t, ".y"}, y, e.y);
        chk({t, ".line_start"}, ls, le);
        chk({t, ".frame_start"}, fs, fe);
        chk({t, ".vblank"}, vb, e.vb);
    endtask

    // inputs are already driven at the current negedge; check, then advance one clock
    task automatic step();
        #1;
        if (rst) begin
            ta = 0; tb_n = 0; lsa = 0; fsa = 0; lsb = 0; fsb = 0;
        end
        pcea = en && !rst && (ta % 4 == 3);
        pceb = en && !rst;
        ea = dec_a(ta / 4);
        eb = dec_b(tb_n);
        cmp("a", ea, pcea, lsa && en, fsa && en, pce_a, hc_a, vc_a, hs_a, vs_a, br_a, x_a, y_a, ls_a, fs_a, vb_a);
        cmp("b", eb, pceb, lsb && en, fsb && en, pce_b, hc_b, vc_b, hs_b, vs_b, br_b, x_b, y_b, ls_b, fs_b, vb_b);
        @(posedge clk);
        if (!rst && en) begin
            ta++; tb_n++;
        end
        ea = dec_a(ta / 4);
        eb = dec_b(tb_n);
        lsa = pcea && ea.h == 0; fsa = lsa && ea.v == 0;
        lsb = pceb && eb.h == 0; fsb = lsb && eb.v == 0;
        @(negedge clk);
    endtask

    initial begin
        int k, runts;
        tbl[0]  = '{1, 0, 2,  6, 4, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{0, 1, 1,  0, 0, 1, 1, 0, 0, 0, 1, 1, 1};
        tbl[2]  = '{0, 1, 1,  1, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{0, 1, 6,  0, 1, 1, 0, 0, 0, 0, 1, 0, 1};
        tbl[4]  = '{0, 1, 16, 2, 3, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 3,  2, 3, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 3,  5, 3, 0, 0, 1, 3, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 1,  6, 3, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 1,  0, 4, 1, 0, 0, 0, 0, 1, 0, 1};
        tbl[9]  = '{0, 1, 7,  0, 0, 1, 1, 0, 0, 0, 1, 1, 1};
        tbl[10] = '{0, 1, 2,  2, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[11] = '{1, 1, 1,  6, 4, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[12] = '{0, 1, 1,  0, 0, 1, 1, 0, 0, 0, 1, 1, 1};
        rst = 1'b1; en = 1'b0; ta = 0; tb_n = 0;
        @(negedge clk);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; en = tbl[i].en;
            repeat (tbl[i].n) step();
            chk($sformatf("tbl%0d.hCount", i), hc_b, tbl[i].h);
            chk($sformatf("tbl%0d.vCount", i), vc_b, tbl[i].v);
            chk($sformatf("tbl%0d.hSync", i), hs_b, tbl[i].hs);
            chk($sformatf("tbl%0d.vSync", i), vs_b, tbl[i].vs);
            chk($sformatf("tbl%0d.bright", i), br_b, tbl[i].br);
            chk($sformatf("tbl%0d.x", i), x_b, tbl[i].x);
            chk($sformatf("tbl%0d.y", i), y_b, tbl[i].y);
            chk($sformatf("tbl%0d.line_start", i), ls_b, tbl[i].ls);
            chk($sformatf("tbl%0d.frame_start", i), fs_b, tbl[i].fs);
            chk($sformatf("tbl%0d.vblank", i), vb_b, tbl[i].vb);
        end

        // default timing: reset values, then first frame_start four clocks after release
        rst = 1'b1; en = 1'b1;
        repeat (5) step();
        chk("a_rst_hCount", hc_a, 799);
        chk("a_rst_vCount", vc_a, 524);
        chk("a_rst_syncs", {hs_a, vs_a}, 2'b11);
        chk("a_rst_bright_vblank", {br_a, vb_a}, 2'b01);
        rst = 1'b0;
        k = 0;
        do begin step(); k++; end while (!fs_a && k < 20);
        chk("a_first_frame_latency", k, 4);
        chk("a_first_pos", {hc_a, vc_a}, 22'd0);
        chk("a_first_syncs", {hs_a, vs_a}, 2'b00);

        // en gap of 37 clocks mid-line stretches the tiny frame from 35 to 72 clocks
        k = 0;
        while (!fs_b && k < 40) begin step(); k++; end
        chk("b_fs_seen", fs_b, 1'b1);
        k = 0;
        do begin
            step(); k++;
            if (k == 10) begin
                en = 1'b0;
                repeat (37) begin step(); k++; end
                en = 1'b1;
            end
        end while (!fs_b && k < 200);
        chk("b_frame_period_en_gap", k, 72);

        // reset between edges while the tiny raster is in its active window
        k = 0;
        while (!br_b && k < 40) begin step(); k++; end
        chk("b_reached_active", br_b, 1'b1);
        rst = 1'b1;
        #1;
        chk("b_async_rst_pos", {hc_b, vc_b}, {11'd6, 11'd4});
        chk("b_async_rst_bright", br_b, 1'b0);
        chk("a_async_rst_pos", {hc_a, vc_a}, {11'd799, 11'd524});
        step();
        rst = 1'b0;
        k = 0; runts = 0;
        do begin step(); k++; if (ls_a && !fs_a) runts++; end while (!fs_a && k < 20);
        chk("a_rst_release_latency", k, 4);
        chk("a_no_runt_line_start", runts, 0);

        repeat (20000) begin
            en  = $urandom_range(0, 7) != 0;
            rst = $urandom_range(0, 999) == 0;
            step();
        end
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 640x480 controller.
- Runs from the single system clock using a pixel clock-enable. It does not use derived clocks.
- Generates hSync/vSync/bright, raster counters, active-area coordinates and frame/line strobes.
- Feeds the frame renderer and pixel RGB mux.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1); 100 MHz -> 25 MHz
CW, 11, width of all counters and coordinates
H_SYNC, 96, horizontal sync width, pixels
H_BP, 48, horizontal back porch, pixels
H_ACTIVE, 640, horizontal visible pixels
H_FP, 16, horizontal front porch, pixels
V_SYNC, 2, vertical sync width, lines
V_BP, 33, vertical back porch, lines
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch, lines
HS_POL, 0, hSync active level
VS_POL, 0, vSync active level

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
en  in  1  run enable; 0 freezes all timing state
pix_ce  out  1  pixel strobe; counters advance on clk edges where pix_ce=1
hCount  out  CW  horizontal position, 0..H_TOTAL-1
vCount  out  CW  vertical position, 0..V_TOTAL-1
hSync  out  1  horizontal sync, registered
vSync  out  1  vertical sync, registered
bright  out  1  inside active area, registered
x  out  CW  active column, 0..H_ACTIVE-1; 0 when bright=0
y  out  CW  active row, 0..V_ACTIVE-1; 0 when bright=0
line_start  out  1  one-clk pulse when hCount becomes 0
frame_start  out  1  one-clk pulse when hCount and vCount both become 0
vblank  out  1  vCount outside the active lines, registered

Behaviour:
- Derived totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (default 800); V_TOTAL likewise (default 525).
- Derived origins: HA0 = H_SYNC+H_BP (144); VA0 = V_SYNC+V_BP (35).
- Region order within each line and frame: sync, back porch, active, front porch.
- Divider: ce_cnt counts 0..CLK_DIV-1 while en=1. pix_ce = en & (ce_cnt==CLK_DIV-1). CLK_DIV=1 gives pix_ce = en.
- en=0: ce_cnt, counters and all registered outputs hold. Pulse outputs are forced to 0.
- On pix_ce:
  - hCount increments. At H_TOTAL-1 it wraps to 0.
  - On that wrap, vCount increments. At V_TOTAL-1 it wraps to 0.
  - Counters never exceed TOTAL-1.
- All decoded outputs are registered and computed from the next counter values. They therefore change on the same edge as hCount/vCount, with zero lag relative to the counters:
  - hSync = HS_POL when hCount < H_SYNC, else ~HS_POL.
  - vSync = VS_POL when vCount < V_SYNC, else ~VS_POL.
  - bright = 1 iff HA0 <= hCount <= HA0+H_ACTIVE-1 and VA0 <= vCount <= VA0+V_ACTIVE-1. Default window is 144..783 by 35..514.
  - x = hCount-HA0 and y = vCount-VA0 when bright=1, else 0.
  - vblank = ~(VA0 <= vCount <= VA0+V_ACTIVE-1).
- line_start is high for exactly one clk, following the edge on which hCount loaded 0.
- frame_start is high for exactly one clk, following the edge on which hCount and vCount both loaded 0. line_start is also high in that clk.
- Reset values (asynchronous):
  - ce_cnt = 0.
  - hCount = H_TOTAL-1, vCount = V_TOTAL-1.
  - hSync = ~HS_POL, vSync = ~VS_POL.
  - bright = 0, x = y = 0, vblank = 1.
  - line_start = frame_start = 0; pix_ce = 0.
- After reset release, the first pix_ce wraps the counters to (0,0) and fires frame_start, so every frame starts clean.
- Reset asserted mid-frame returns all state to the reset values within the same cycle. No partial pulse is emitted.
- Arithmetic is unsigned CW-bit. Elaboration must fail if H_TOTAL or V_TOTAL > 2^CW.

Test Plan:
- Reset, defaults:
  - hold rst 5 clks -> hCount=799, vCount=524, hSync=vSync=1, bright=0, vblank=1.
  - release -> first pix_ce at clk 4 after release; frame_start pulses once; hCount=0, vCount=0, hSync=0, vSync=0.
- Full frame, defaults:
  - frame_start period = 800*525*4 = 1,680,000 clks.
  - hSync low for 96 pixels per line; vSync low for 2 lines.
  - bright high for exactly 307,200 pixels per frame.
  - first bright at (144,35) with x=0, y=0; last at (783,514) with x=639, y=479.
- CLK_DIV=1, H_ACTIVE=4, H_FP=H_BP=H_SYNC=1, V_* = 1,2,1,1, HS_POL=VS_POL=1:
  - pix_ce constantly 1.
  - line period 7 clks; frame period 35 clks.
  - hSync high only at hCount=0.
- en toggling:
  - drop en for 37 clks mid-line -> counters and outputs frozen; no pix_ce or pulses.
  - restore en -> sequence resumes exactly where it stopped; frame period extends by exactly 37 clks.
- Reset mid-active (hCount=400, vCount=200):
  - assert rst between clk edges -> outputs go to reset values immediately.
  - after release -> clean frame_start; no runt line_start.
- Wrap corner: hCount=799, vCount=514, pix_ce -> hCount=0, vCount=515, line_start=1, frame_start=0, vblank=1, bright=0.
